// File: rtl/oct_pkg.sv
// Shared definitions for the psum output collector: bus/address width defaults
// and the collector FSM state type.
package oct_pkg;

  localparam int unsigned OCT_DATA_WIDTH = 16;
  localparam int unsigned OCT_ADDR_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } oct_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags. A push is ignored when
// the FIFO is full, even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/psum_out_collector.sv
// Collects one pass of psums from the router bus, packs pairs into global-buffer
// words, and writes them out through a FIFO at auto-incrementing addresses.
module psum_out_collector
  import oct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = OCT_DATA_WIDTH,
  parameter int unsigned ADDR_W     = OCT_ADDR_W,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    config_state,
  input  logic                    cfg_load,
  input  logic [CNT_W-1:0]        cfg_psum_num,
  input  logic [ADDR_W-1:0]       cfg_base_addr,
  input  logic                    psum_out_start_in,
  input  logic [DATA_WIDTH-1:0]   bus_data,
  input  logic                    bus_data_en,
  output logic [2*DATA_WIDTH-1:0] gb_wdata,
  output logic [ADDR_W-1:0]       gb_waddr,
  output logic                    gb_wvalid,
  input  logic                    gb_wready,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  oct_state_e state, state_nxt;

  logic [CNT_W-1:0]        cfg_num_q;
  logic [ADDR_W-1:0]       cfg_base_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_inc;
  logic [DATA_WIDTH-1:0]   half_q;
  logic                    ovf_q;
  logic [ADDR_W-1:0]       addr_q;

  logic                    fifo_push;
  logic [2*DATA_WIDTH-1:0] fifo_din;
  logic [2*DATA_WIDTH-1:0] fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    wr_fire;
  logic                    accept;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign wr_fire = !fifo_empty && gb_wready;
  assign accept  = (state == ST_COLLECT) && bus_data_en;

  sync_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (wr_fire),
    .rd_data   (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Odd count parity means the half register already holds the first psum of a pair.
  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    fifo_din  = {bus_data, half_q};
    unique case (state)
      ST_IDLE: begin
        if (psum_out_start_in)
          state_nxt = (cfg_num_q == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (bus_data_en) begin
          fifo_push = cnt_q[0];
          if (cnt_inc == cfg_num_q)
            state_nxt = cnt_q[0] ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        fifo_din = {{DATA_WIDTH{1'b0}}, half_q};
        if (!fifo_full) begin
          fifo_push = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_num_q  <= '0;
      cfg_base_q <= '0;
      cnt_q      <= '0;
      half_q     <= '0;
      ovf_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      if (state == ST_IDLE && config_state && cfg_load) begin
        cfg_num_q  <= cfg_psum_num;
        cfg_base_q <= cfg_base_addr;
      end

      if (state == ST_IDLE && psum_out_start_in) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (accept) begin
        cnt_q <= cnt_inc;
        if (!cnt_q[0])              half_q <= bus_data;
        else if (fifo_full)         ovf_q  <= 1'b1;
      end

      if (state == ST_IDLE && psum_out_start_in) addr_q <= cfg_base_q;
      else if (wr_fire)                          addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign gb_wvalid = !fifo_empty;
  assign gb_wdata  = fifo_dout;
  assign gb_waddr  = addr_q;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign overflow  = ovf_q;

endmodule
